// File: rtl/mastermind_pkg.sv
// Shared types and helpers for the Mastermind game blocks.
//   state_t     : turn timer FSM states
//   bcd_digit_t : one BCD display digit
//   to_bcd      : converts 0..99 to a packed {tens, ones} BCD pair
package mastermind_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic [7:0] to_bcd(input int unsigned value);
    int unsigned tens;
    int unsigned ones;
    tens = (value / 32'd10) % 32'd10;
    ones = value % 32'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with synchronous load and decrement enable.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset (resets to LOAD_VAL)
//   load_i       : load LOAD_VAL (has priority over dec_i)
//   dec_i        : decrement by one; saturates at 00
//   tens_o/ones_o: registered BCD digits
//   zero_o       : digits read 00
//   one_o        : digits read 01 (next decrement reaches 00)
module bcd_down_counter
  import mastermind_pkg::*;
#(
  parameter logic [7:0] LOAD_VAL = 8'h30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic       dec_i,
  output bcd_digit_t tens_o,
  output bcd_digit_t ones_o,
  output logic       zero_o,
  output logic       one_o
);

  bcd_digit_t tens_q, tens_d;
  bcd_digit_t ones_q, ones_d;
  logic       zero_s;

  assign zero_s = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Next-state of the digit pair: load, borrow-aware decrement, or hold.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load_i) begin
      tens_d = LOAD_VAL[7:4];
      ones_d = LOAD_VAL[3:0];
    end else if (dec_i && !zero_s) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
        tens_d = tens_q;
      end
    end else begin
      tens_d = tens_q;
      ones_d = ones_q;
    end
  end

  // Digit registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tens_q <= LOAD_VAL[7:4];
      ones_q <= LOAD_VAL[3:0];
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;
  assign zero_o = zero_s;
  assign one_o  = (tens_q == 4'd0) && (ones_q == 4'd1);

endmodule

// File: rtl/turn_timer.sv
// Per-guess countdown timer for Mastermind.
// Counts down START_SECS seconds (TICKS_PER_SEC divider ticks each) and
// drives BCD digits, a blinking low-time warning and a timeout pulse.
// Ports:
//   clock, reset          : system clock, asynchronous active-high reset
//   tick                  : single-cycle enable from the rate divider
//   start                 : begin a new turn (any state)
//   pause                 : level, freezes the countdown
//   stop                  : guess submitted, end turn holding the digits
//   secs_tens, secs_ones  : BCD remaining seconds
//   running               : RUN or PAUSED
//   expired               : in EXPIRED
//   timeout               : one-cycle pulse on entry to EXPIRED
//   warn                  : blink output while time is low
module turn_timer
  import mastermind_pkg::*;
#(
  parameter int unsigned START_SECS    = 30,
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned WARN_SECS     = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output bcd_digit_t secs_tens,
  output bcd_digit_t secs_ones,
  output logic       running,
  output logic       expired,
  output logic       timeout,
  output logic       warn
);

  localparam logic [7:0]      LOAD_BCD   = to_bcd(START_SECS);
  localparam logic [7:0]      WARN_BCD   = to_bcd(WARN_SECS);
  localparam int unsigned     PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          timeout_q, timeout_d;
  logic          warn_q, warn_d;

  bcd_digit_t    tens_s, ones_s;
  logic          zero_s, one_s;
  logic          tick_run_s, dec_s, reach_zero_s;
  logic          in_warn_s, above_warn_s;

  // A tick only counts in RUN when no higher-priority event is present.
  assign tick_run_s   = (state_q == RUN) && !start && !stop && !pause && tick;
  assign dec_s        = tick_run_s && (presc_q == PRESC_LAST);
  assign reach_zero_s = dec_s && one_s;
  // Packed BCD compares in the same order as the decimal value.
  assign above_warn_s = {tens_s, ones_s} > WARN_BCD;
  assign in_warn_s    = !above_warn_s && !zero_s;

  bcd_down_counter #(
    .LOAD_VAL (LOAD_BCD)
  ) u_digits (
    .clock  (clock),
    .reset  (reset),
    .load_i (start),
    .dec_i  (dec_s),
    .tens_o (tens_s),
    .ones_o (ones_s),
    .zero_o (zero_s),
    .one_o  (one_s)
  );

  // FSM state and prescaler registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // Next-state and prescaler logic; start overrides everything.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (start) begin
      state_d = RUN;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (pause) begin
            state_d = PAUSED;
          end else if (reach_zero_s) begin
            state_d = EXPIRED;
          end else begin
            state_d = RUN;
          end
        end
        PAUSED: begin
          if (stop) begin
            state_d = IDLE;
          end else if (!pause) begin
            state_d = RUN;
          end else begin
            state_d = PAUSED;
          end
        end
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
      if (tick_run_s) begin
        presc_d = dec_s ? '0 : presc_q + PW'(1);
      end else begin
        presc_d = presc_q;
      end
    end
  end

  // Output next-values, derived from the upcoming state.
  always_comb begin
    running_d = (state_d == RUN) || (state_d == PAUSED);
    expired_d = (state_d == EXPIRED);
    timeout_d = reach_zero_s;
    warn_d    = warn_q;
    if (start) begin
      warn_d = 1'b0;
    end else begin
      case (state_d)
        RUN: begin
          if (tick_run_s) begin
            warn_d = in_warn_s ? !warn_q : 1'b0;
          end else if (above_warn_s) begin
            warn_d = 1'b0;
          end else begin
            warn_d = warn_q;
          end
        end
        PAUSED:  warn_d = warn_q;
        IDLE:    warn_d = 1'b0;
        EXPIRED: warn_d = 1'b0;
        default: warn_d = 1'b0;
      endcase
    end
  end

  // Registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      running_q <= 1'b0;
      expired_q <= 1'b0;
      timeout_q <= 1'b0;
      warn_q    <= 1'b0;
    end else begin
      running_q <= running_d;
      expired_q <= expired_d;
      timeout_q <= timeout_d;
      warn_q    <= warn_d;
    end
  end

  assign secs_tens = tens_s;
  assign secs_ones = ones_s;
  assign running   = running_q;
  assign expired   = expired_q;
  assign timeout   = timeout_q;
  assign warn      = warn_q;

endmodule

// File: tb/tb_turn_timer.sv
// Directed bench for turn_timer with START_SECS=12, TICKS_PER_SEC=2, WARN_SECS=5.
module tb_turn_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop  = 1'b0;
  logic [3:0] secs_tens, secs_ones;
  logic       running, expired, timeout, warn;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       start, stop, pause, tick;
    logic [3:0] tens, ones;
    logic       running, expired, timeout, warn;
  } vec_t;

  localparam int NV = 52;
  vec_t vecs [NV];

  turn_timer #(
    .START_SECS    (12),
    .TICKS_PER_SEC (2),
    .WARN_SECS     (5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .secs_tens (secs_tens),
    .secs_ones (secs_ones),
    .running   (running),
    .expired   (expired),
    .timeout   (timeout),
    .warn      (warn)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input int st, sp, pa, tk, tn, on, rn, ex, to, wn);
    vec_t v;
    v.start = st[0]; v.stop = sp[0]; v.pause = pa[0]; v.tick = tk[0];
    v.tens = tn[3:0]; v.ones = on[3:0];
    v.running = rn[0]; v.expired = ex[0]; v.timeout = to[0]; v.warn = wn[0];
    return v;
  endfunction

  task automatic check(input string name, input int tn, on, rn, ex, to, wn);
    n_cmp++;
    if (secs_tens !== tn[3:0] || secs_ones !== on[3:0] || running !== rn[0] ||
        expired !== ex[0] || timeout !== to[0] || warn !== wn[0]) begin
      n_bad++;
      $display("FAIL %s: got digits=%h%h run=%b exp=%b to=%b warn=%b, want digits=%0d%0d run=%0d exp=%0d to=%0d warn=%0d",
               name, secs_tens, secs_ones, running, expired, timeout, warn, tn, on, rn, ex, to, wn);
    end
  endtask

  task automatic drive(input logic st, sp, pa, tk);
    start = st; stop = sp; pause = pa; tick = tk;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int r;
    int n_ticks;
    bit seen;

    // Table: {start, stop, pause, tick} -> {tens, ones, running, expired, timeout, warn}
    vecs[0]  = mk(0,0,0,1, 1,2, 0,0,0,0);   // tick in IDLE ignored
    vecs[1]  = mk(1,0,0,0, 1,2, 1,0,0,0);   // start
    vecs[2]  = mk(0,0,0,1, 1,2, 1,0,0,0);
    vecs[3]  = mk(0,0,0,1, 1,1, 1,0,0,0);
    vecs[4]  = mk(0,0,0,0, 1,1, 1,0,0,0);
    vecs[5]  = mk(0,0,0,1, 1,1, 1,0,0,0);   // prescaler now mid-second
    vecs[6]  = mk(0,0,1,1, 1,1, 1,0,0,0);   // pause wins over tick
    vecs[7]  = mk(0,0,1,1, 1,1, 1,0,0,0);
    vecs[8]  = mk(0,0,1,0, 1,1, 1,0,0,0);
    vecs[9]  = mk(0,0,0,1, 1,1, 1,0,0,0);   // leaving PAUSED, tick ignored
    vecs[10] = mk(0,0,0,1, 1,0, 1,0,0,0);   // phase preserved: one tick finishes the second
    vecs[11] = mk(0,0,0,1, 1,0, 1,0,0,0);
    vecs[12] = mk(0,0,0,1, 0,9, 1,0,0,0);   // borrow 10 -> 09
    vecs[13] = mk(0,0,0,1, 0,9, 1,0,0,0);
    vecs[14] = mk(0,1,0,1, 0,9, 0,0,0,0);   // stop + tick: digits held
    vecs[15] = mk(0,0,0,1, 0,9, 0,0,0,0);
    vecs[16] = mk(0,1,0,0, 0,9, 0,0,0,0);
    vecs[17] = mk(1,1,0,0, 1,2, 1,0,0,0);   // start beats stop
    for (int k = 0; k < 14; k++) begin
      r = 12 - (k + 1) / 2;
      vecs[18 + k] = mk(0,0,0,1, r / 10, r % 10, 1,0,0,0);
    end
    vecs[32] = mk(0,0,0,1, 0,5, 1,0,0,1);   // warn starts blinking at 05
    vecs[33] = mk(0,0,0,1, 0,4, 1,0,0,0);
    vecs[34] = mk(0,0,0,1, 0,4, 1,0,0,1);
    vecs[35] = mk(0,0,1,0, 0,4, 1,0,0,1);   // warn held while paused
    vecs[36] = mk(0,0,1,1, 0,4, 1,0,0,1);
    vecs[37] = mk(0,0,0,0, 0,4, 1,0,0,1);
    vecs[38] = mk(0,0,0,1, 0,3, 1,0,0,0);
    vecs[39] = mk(0,0,0,1, 0,3, 1,0,0,1);
    vecs[40] = mk(0,0,0,1, 0,2, 1,0,0,0);
    vecs[41] = mk(0,0,0,1, 0,2, 1,0,0,1);
    vecs[42] = mk(0,0,0,1, 0,1, 1,0,0,0);
    vecs[43] = mk(0,0,0,1, 0,1, 1,0,0,1);
    vecs[44] = mk(0,0,0,1, 0,0, 0,1,1,0);   // reach 00: timeout pulse
    vecs[45] = mk(0,0,0,1, 0,0, 0,1,0,0);
    vecs[46] = mk(0,0,0,0, 0,0, 0,1,0,0);
    vecs[47] = mk(0,1,0,0, 0,0, 0,1,0,0);   // stop ignored in EXPIRED
    vecs[48] = mk(0,0,1,1, 0,0, 0,1,0,0);
    vecs[49] = mk(1,0,0,1, 1,2, 1,0,0,0);   // start + tick from EXPIRED
    vecs[50] = mk(0,0,0,1, 1,2, 1,0,0,0);
    vecs[51] = mk(0,0,0,1, 1,1, 1,0,0,0);

    // Reset, released between edges.
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    #1 check("reset_state", 1,2, 0,0,0,0);
    @(posedge clock);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].tick);
      check($sformatf("vec[%0d]", i), vecs[i].tens, vecs[i].ones, vecs[i].running,
            vecs[i].expired, vecs[i].timeout, vecs[i].warn);
    end

    // Async reset mid-turn with the prescaler mid-second.
    drive(0,0,0,1);
    check("pre_reset", 1,1, 1,0,0,0);
    #2 reset = 1'b1;
    #1 check("async_reset", 1,2, 0,0,0,0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    drive(0,0,0,1);
    drive(0,0,0,1);
    check("tick_after_reset", 1,2, 0,0,0,0);
    drive(1,0,0,0);
    check("start_after_reset", 1,2, 1,0,0,0);
    drive(0,0,0,1);
    check("presc_cleared_by_reset", 1,2, 1,0,0,0);
    drive(0,0,0,1);
    check("first_sec_after_reset", 1,1, 1,0,0,0);

    // Full turn: exactly 12 * 2 accepted ticks from start to timeout.
    drive(1,0,0,0);
    n_ticks = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      drive(0,0,0,1);
      n_ticks++;
      if (timeout === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || n_ticks != 24) begin
      n_bad++;
      $display("FAIL turn_length: got %0d ticks (timeout seen=%0d), want 24", n_ticks, seen);
    end
    check("turn_end_state", 0,0, 0,1,1,0);
    drive(0,0,0,0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/turn_timer.md
# turn_timer

Per-guess countdown timer for the Mastermind game, directly downstream of the rate divider. It consumes the divider's slow tick, a single-cycle enable in the system clock domain, and counts down the seconds a player has left to submit a guess. It drives two BCD digits for the HEX display, a blinking low-time warning, and a one-cycle timeout event to the game controller.

## Interface
Parameters:
- START_SECS, 30, seconds loaded at each turn start; legal range 1..99 (0 is illegal).
- TICKS_PER_SEC, 1, tick pulses per displayed second; legal range ≥1.
- WARN_SECS, 5, warning threshold; warn blinks while remaining ≤ WARN_SECS; legal range 0..START_SECS.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  single-cycle enable from the rate divider, synchronous to clock.
- start  in  1  pulse; begins a new turn.
- pause  in  1  level; freezes the countdown while high.
- stop  in  1  pulse; a guess was submitted, so end the turn and freeze the display.
- secs_tens  out  4  BCD tens digit of remaining seconds.
- secs_ones  out  4  BCD ones digit of remaining seconds.
- running  out  1  high in RUN or PAUSED.
- expired  out  1  level; high in EXPIRED.
- timeout  out  1  one-cycle pulse on entry to EXPIRED.
- warn  out  1  blink output for the low-time LED.

## Operation
- FSM states are IDLE, RUN, PAUSED and EXPIRED. Reset places the FSM in IDLE.
- Reset values: digits = BCD(START_SECS), prescaler = 0, and running, expired, timeout and warn = 0.
- Event priority per cycle is reset > start > stop > pause > tick.
- start, in any state: load BCD(START_SECS), clear the prescaler and warn, and go to RUN.
- stop, in RUN or PAUSED: go to IDLE with the digits held. stop is ignored in IDLE and EXPIRED.
- pause high in RUN: go to PAUSED. pause low in PAUSED: go to RUN. Ticks are ignored while in PAUSED. The prescaler holds its value across a pause.
- tick in RUN:
  - If prescaler = TICKS_PER_SEC−1, clear the prescaler and decrement the BCD pair (ones 0 → 9 with a tens borrow).
  - Otherwise, increment the prescaler.
- The decrement that reaches 00 goes to EXPIRED and asserts timeout for exactly one cycle. The digits hold 00 until the next start.
- Ticks are ignored in IDLE and EXPIRED.
- warn:
  - In RUN, warn toggles on every tick while remaining ≤ WARN_SECS and remaining > 0.
  - In PAUSED, warn holds its value.
  - warn is forced to 0 in IDLE and EXPIRED, and whenever remaining > WARN_SECS.
- Only one BCD decrement can occur per clock. The counter never underflows below 00.

## Timing
- All outputs are registered.
- A tick sampled at edge N updates the prescaler, digits, warn and state at edge N, visible in cycle N+1.
- timeout is high in the same cycle that the digits first read 00 and expired rises.
- start at edge N: running = 1 and digits = START_SECS from cycle N+1. A coincident tick is discarded.
- stop coincident with a tick: the tick is discarded and the digits are unchanged.
- start coincident with stop: start wins.
- Reset asserted mid-turn clears the block immediately (asynchronously). The first start is honoured on the first edge after reset deasserts.
- Turn duration from start to timeout is exactly START_SECS × TICKS_PER_SEC accepted ticks.

## Structure
- mastermind_pkg holds the state enum (IDLE/RUN/PAUSED/EXPIRED) and the BCD digit type.
- mastermind_pkg also holds a to_bcd helper function used to form the load constant.
- Sub-module bcd_down_counter holds the two-digit BCD register with load, decrement-enable and a zero flag.
- turn_timer itself holds the FSM, prescaler and warn logic.

## Test plan
- Basic countdown (START_SECS=3, TICKS_PER_SEC=1): reset, start, then 3 ticks. Digits must read 03 → 02 → 01 → 00. timeout pulses once with the 00 update, then expired=1 and running=0.
- Borrow check (START_SECS=30, TICKS_PER_SEC=2): start, then 2 ticks gives 29; 20 ticks gives 20; 2 more ticks gives 19.
- Pause: during RUN hold pause high across 5 ticks. Digits stay frozen and running=1. After release, counting resumes with the prescaler phase preserved.
- Collisions:
  - stop coincident with a tick: the block goes to IDLE with the digits unchanged.
  - start coincident with a tick from EXPIRED: the digits reload to START_SECS with no decrement.
- Warning (START_SECS=8, WARN_SECS=5): warn stays 0 until the digits reach 05, then toggles on each tick at 05..01. warn is 0 once expired.
- Async reset asserted between clock edges mid-turn: all outputs return to their reset values immediately. Ticks are ignored until the next start.
